ky32_wb_arbiter: RTL and testbench

//  Writer side of the KY32 register-file write port. Merges results from the ALU and load unit

---
 rtl/ky32_wb_arbiter.sv | 95 +++++++++
 tb/tb_ky32_wb_arbiter.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/ky32_wb_arbiter.sv
// KY32 writeback arbiter: merges ALU and load results onto the single
// register-file write port and tracks pending writes in a busy bitmap.
module ky32_wb_arbiter #(
  parameter int XLEN       = 32,
  parameter int AW         = 5,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  input  logic [AW-1:0]     alu_rd,
  input  logic [XLEN-1:0]   alu_data,
  output logic              alu_ready,
  input  logic              ld_valid,
  input  logic [AW-1:0]     ld_rd,
  input  logic [XLEN-1:0]   ld_data,
  output logic              ld_ready,
  input  logic              iss_valid,
  input  logic [AW-1:0]     iss_rd,
  output logic              we,
  output logic [AW-1:0]     w_addr,
  output logic [XLEN-1:0]   wd,
  output logic [2**AW-1:0]  busy
);

  localparam int NREG = 2**AW;
  localparam int SW   = $clog2(STARVE_MAX + 1);

  logic [SW-1:0]   r_starve;
  logic            r_we;
  logic [AW-1:0]   r_waddr;
  logic [XLEN-1:0] r_wd;
  logic [NREG-1:0] r_busy;

  logic            w_force;
  logic            w_xfer;
  logic [AW-1:0]   w_rd;
  logic [XLEN-1:0] w_data;
  logic [NREG-1:0] w_set;
  logic [NREG-1:0] w_clr;

  // A starved ALU overrides the load unit's default priority.
  assign w_force   = (r_starve == SW'(STARVE_MAX));
  assign alu_ready = alu_valid && (!ld_valid || w_force);
  assign ld_ready  = ld_valid && (!alu_valid || !w_force);

  assign w_xfer = alu_ready || ld_ready;
  assign w_rd   = alu_ready ? alu_rd : ld_rd;
  assign w_data = alu_ready ? alu_data : ld_data;

  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (iss_valid) w_set[iss_rd] = 1'b1;
    if (w_xfer)    w_clr[w_rd]   = 1'b1;
    w_set[0] = 1'b0;
    w_clr[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_starve <= '0;
    end else if (alu_valid && !alu_ready) begin
      if (!w_force) r_starve <= r_starve + SW'(1);
    end else begin
      r_starve <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wd    <= '0;
    end else begin
      r_we <= w_xfer && (w_rd != '0);
      if (w_xfer) begin
        r_waddr <= w_rd;
        r_wd    <= w_data;
      end
    end
  end

  // Set after clear so a same-edge reissue keeps the newer producer busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_busy <= '0;
    else     r_busy <= (r_busy & ~w_clr) | w_set;
  end

  assign we     = r_we;
  assign w_addr = r_waddr;
  assign wd     = r_wd;
  assign busy   = r_busy;

endmodule

// File: tb/tb_ky32_wb_arbiter.sv
// Directed self-checking bench for ky32_wb_arbiter.
// Inputs change 1ns after posedge; outputs sampled 2ns after posedge.
module tb_ky32_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        ld_valid;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic        ld_ready;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic        we;
  logic [4:0]  w_addr;
  logic [31:0] wd;
  logic [31:0] busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ky32_wb_arbiter dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd),
    .alu_data(alu_data), .alu_ready(alu_ready),
    .ld_valid(ld_valid), .ld_rd(ld_rd),
    .ld_data(ld_data), .ld_ready(ld_ready),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .we(we), .w_addr(w_addr), .wd(wd), .busy(busy)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst = 1'b1;
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    ld_valid = 0;  ld_rd = 0;  ld_data = 0;
    iss_valid = 0; iss_rd = 0;
    tick(); tick();
    rst = 1'b0;
    settle();
    chk("rst_we", we, 0);
    chk("rst_waddr", w_addr, 0);
    chk("rst_wd", wd, 0);
    chk("rst_busy", busy, 0);

    // single ALU write
    alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
    settle();
    chk("t2_alu_ready", alu_ready, 1);
    chk("t2_ld_ready", ld_ready, 0);
    tick();
    alu_valid = 0;
    settle();
    chk("t2_we", we, 1);
    chk("t2_waddr", w_addr, 5);
    chk("t2_wd", wd, 32'hDEADBEEF);
    chk("t2_busy", busy, 0);
    tick();
    chk("t2_we_off", we, 0);
    chk("t2_waddr_hold", w_addr, 5);

    // both valid: load wins, ALU next
    alu_valid = 1; alu_rd = 4; alu_data = 32'h44;
    ld_valid = 1;  ld_rd = 3;  ld_data = 32'h33;
    settle();
    chk("t3_ld_ready", ld_ready, 1);
    chk("t3_alu_ready", alu_ready, 0);
    tick();
    ld_valid = 0;
    settle();
    chk("t3_we1", we, 1);
    chk("t3_waddr1", w_addr, 3);
    chk("t3_wd1", wd, 32'h33);
    chk("t3_alu_ready2", alu_ready, 1);
    tick();
    alu_valid = 0;
    settle();
    chk("t3_we2", we, 1);
    chk("t3_waddr2", w_addr, 4);
    chk("t3_wd2", wd, 32'h44);
    tick();

    // starvation: ALU forced to win in 5th contended cycle
    alu_valid = 1; alu_rd = 10; alu_data = 32'hA;
    ld_valid = 1;  ld_rd = 9;   ld_data = 32'h9;
    for (int c = 1; c <= 8; c++) begin
      settle();
      chk($sformatf("t4_alu_ready_c%0d", c), alu_ready, (c == 5));
      chk($sformatf("t4_ld_ready_c%0d", c), ld_ready, (c != 5));
      tick();
      chk($sformatf("t4_waddr_c%0d", c), w_addr, (c == 5) ? 10 : 9);
    end
    alu_valid = 0; ld_valid = 0;
    tick();

    // rd == 0 accepted but never written
    alu_valid = 1; alu_rd = 0; alu_data = 32'h1;
    settle();
    chk("t5_alu_ready", alu_ready, 1);
    tick();
    alu_valid = 0;
    settle();
    chk("t5_we", we, 0);
    chk("t5_busy", busy, 0);
    tick();

    // scoreboard set/clear
    iss_valid = 1; iss_rd = 7;
    tick();
    iss_valid = 0;
    settle();
    chk("t6_busy_set", busy, 32'h80);
    ld_valid = 1; ld_rd = 7; ld_data = 32'h77;
    iss_valid = 1; iss_rd = 7;
    settle();
    chk("t6_ld_ready", ld_ready, 1);
    tick();
    ld_valid = 0; iss_valid = 0;
    settle();
    chk("t6_busy_setwins", busy, 32'h80);
    chk("t6_we", we, 1);
    chk("t6_waddr", w_addr, 7);
    ld_valid = 1; ld_rd = 7; ld_data = 32'h78;
    tick();
    ld_valid = 0;
    settle();
    chk("t6_busy_clr", busy, 0);
    chk("t6_wd", wd, 32'h78);
    tick();

    // async reset mid-write
    alu_valid = 1; alu_rd = 12; alu_data = 32'hAA;
    iss_valid = 1; iss_rd = 20;
    tick();
    alu_valid = 0; iss_valid = 0;
    settle();
    chk("t1_we_pre", we, 1);
    chk("t1_busy_pre", busy, 32'h0010_0000);
    rst = 1'b1;
    #1;
    chk("t1_we", we, 0);
    chk("t1_waddr", w_addr, 0);
    chk("t1_wd", wd, 0);
    chk("t1_busy", busy, 0);
    tick();
    rst = 1'b0;
    tick();
    chk("t1_we_after", we, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
